// File: rtl/pc_branch_unit_if.sv
// Bus bundle for pc_branch_unit: the fetch-stage request (PC, offset, branch
// type, zero flag) and the registered next-PC result.
interface pc_branch_unit_if #(
  parameter int WIDTH     = 32,
  parameter int IMM_WIDTH = 16
);
  logic                 in_valid;
  logic [WIDTH-1:0]     PC;
  logic [IMM_WIDTH-1:0] immediate;
  logic                 branch_eq;
  logic                 branch_ne;
  logic                 zero;

  logic                 out_valid;
  logic [WIDTH-1:0]     PCBranch;
  logic [WIDTH-1:0]     PCPlus4;
  logic                 taken;
  logic [WIDTH-1:0]     pc_next;
  logic                 wrapped;
  logic                 misaligned;

  modport master (
    output in_valid, PC, immediate, branch_eq, branch_ne, zero,
    input  out_valid, PCBranch, PCPlus4, taken, pc_next, wrapped, misaligned
  );

  modport slave (
    input  in_valid, PC, immediate, branch_eq, branch_ne, zero,
    output out_valid, PCBranch, PCPlus4, taken, pc_next, wrapped, misaligned
  );
endinterface

// File: rtl/pc_branch_unit.sv
// Branch-target generator for the MIPS fetch stage: computes PC+4 and the
// branch target, resolves BEQ/BNE, and registers the selected next PC.
module pc_branch_unit #(
  parameter int WIDTH     = 32,
  parameter int IMM_WIDTH = 16
) (
  input logic              clk,
  input logic              rst_n,
  pc_branch_unit_if.slave  bus
);

  logic [WIDTH-1:0] sext;
  logic [WIDTH-1:0] off;
  logic [WIDTH-1:0] plus4;
  logic [WIDTH-1:0] target;
  logic             carry_plus4;
  logic             carry_target;
  logic             off_neg;
  logic             taken_d;
  logic             wrapped_d;

  assign sext    = {{(WIDTH-IMM_WIDTH){bus.immediate[IMM_WIDTH-1]}}, bus.immediate};
  assign off     = sext << 2;
  assign off_neg = bus.immediate[IMM_WIDTH-1];

  assign {carry_plus4, plus4}   = {1'b0, bus.PC} + {{(WIDTH-2){1'b0}}, 3'd4};
  assign {carry_target, target} = {1'b0, plus4} + {1'b0, off};

  // Adding a negative offset in two's complement sets the carry when the result
  // stays in range, so a borrow out of WIDTH bits shows up as a missing carry.
  assign wrapped_d = carry_plus4 | (off_neg ? ~carry_target : carry_target);
  assign taken_d   = (bus.branch_eq & bus.zero) | (bus.branch_ne & ~bus.zero);

  logic             out_valid_q;
  logic [WIDTH-1:0] pc_branch_q;
  logic [WIDTH-1:0] pc_plus4_q;
  logic             taken_q;
  logic [WIDTH-1:0] pc_next_q;
  logic             wrapped_q;
  logic             misaligned_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; data registers are reset too so outputs read 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      pc_branch_q  <= '0;
      pc_plus4_q   <= '0;
      taken_q      <= 1'b0;
      pc_next_q    <= '0;
      wrapped_q    <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        pc_branch_q  <= target;
        pc_plus4_q   <= plus4;
        taken_q      <= taken_d;
        pc_next_q    <= taken_d ? target : plus4;
        wrapped_q    <= wrapped_d;
        misaligned_q <= |bus.PC[1:0];
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.PCBranch   = pc_branch_q;
  assign bus.PCPlus4    = pc_plus4_q;
  assign bus.taken      = taken_q;
  assign bus.pc_next    = pc_next_q;
  assign bus.wrapped    = wrapped_q;
  assign bus.misaligned = misaligned_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit: directed literal cases, async reset
// behaviour, and randomized traffic compared against a wide-integer model.
module tb_pc_branch_unit;
  localparam int W  = 32;
  localparam int IW = 16;
  localparam longint TWO32 = 64'sh1_0000_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pc_branch_unit_if #(.WIDTH(W), .IMM_WIDTH(IW)) bus ();

  pc_branch_unit #(.WIDTH(W), .IMM_WIDTH(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_total = 0;
  int n_pass  = 0;
  bit cmp_en  = 1'b0;

  typedef struct {
    bit         valid;
    logic [W-1:0] branch;
    logic [W-1:0] plus4;
    bit         taken;
    logic [W-1:0] next;
    bit         wrapped;
    bit         mis;
  } exp_t;

  exp_t m;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: do the arithmetic in 64-bit signed integers and detect wrap by range.
  function automatic exp_t predict(logic [W-1:0] pc, logic [IW-1:0] imm,
                                   bit beq, bit bne, bit z);
    exp_t e;
    logic signed [IW-1:0] si;
    longint off, p4, tgt;
    si  = imm;
    off = longint'(si) * 64'sd4;
    p4  = longint'(pc) + 64'sd4;
    tgt = (p4 % TWO32) + off;
    e.valid   = 1'b1;
    e.plus4   = p4[W-1:0];
    e.branch  = tgt[W-1:0];
    e.taken   = (beq && z) || (bne && !z);
    e.next    = e.taken ? e.branch : e.plus4;
    e.wrapped = (p4 >= TWO32) || (tgt < 0) || (tgt >= TWO32);
    e.mis     = (pc[1:0] != 2'b00);
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m = '{default: 0};
    else if (bus.in_valid)
      m = predict(bus.PC, bus.immediate, bus.branch_eq, bus.branch_ne, bus.zero);
    else m.valid = 1'b0;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_out_valid",  64'(bus.out_valid),  64'(m.valid));
      check("cmp_PCBranch",   64'(bus.PCBranch),   64'(m.branch));
      check("cmp_PCPlus4",    64'(bus.PCPlus4),    64'(m.plus4));
      check("cmp_taken",      64'(bus.taken),      64'(m.taken));
      check("cmp_pc_next",    64'(bus.pc_next),    64'(m.next));
      check("cmp_wrapped",    64'(bus.wrapped),    64'(m.wrapped));
      check("cmp_misaligned", 64'(bus.misaligned), 64'(m.mis));
    end
  end

  task automatic drive(logic [W-1:0] pc, logic [IW-1:0] imm,
                       bit beq, bit bne, bit z, bit v);
    bus.in_valid  = v;
    bus.PC        = pc;
    bus.immediate = imm;
    bus.branch_eq = beq;
    bus.branch_ne = bne;
    bus.zero      = z;
  endtask

  task automatic step(logic [W-1:0] pc, logic [IW-1:0] imm,
                      bit beq, bit bne, bit z, bit v);
    drive(pc, imm, beq, bne, z, v);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(string tag, bit v, logic [W-1:0] br, logic [W-1:0] p4,
                            bit tk, logic [W-1:0] nx, bit wr, bit mis);
    check({tag, "_out_valid"},  64'(bus.out_valid),  64'(v));
    check({tag, "_PCBranch"},   64'(bus.PCBranch),   64'(br));
    check({tag, "_PCPlus4"},    64'(bus.PCPlus4),    64'(p4));
    check({tag, "_taken"},      64'(bus.taken),      64'(tk));
    check({tag, "_pc_next"},    64'(bus.pc_next),    64'(nx));
    check({tag, "_wrapped"},    64'(bus.wrapped),    64'(wr));
    check({tag, "_misaligned"}, 64'(bus.misaligned), 64'(mis));
  endtask

  initial begin
    logic [W-1:0]  pc;
    logic [IW-1:0] imm;
    rst_n = 1'b1;
    drive('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1 expect_out("reset_async", 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 expect_out("reset_held", 0, 0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b1;
    cmp_en = 1'b1;
    @(posedge clk);
    #1;

    step(32'h0000_1000, 16'h0004, 1, 0, 1, 1);
    expect_out("pos_off", 1, 32'h0000_1014, 32'h0000_1004, 1, 32'h0000_1014, 0, 0);
    step(32'h0000_1000, 16'hFFFC, 0, 1, 1, 1);
    expect_out("neg_off", 1, 32'h0000_0FF4, 32'h0000_1004, 0, 32'h0000_1004, 0, 0);
    step(32'hFFFF_FFF8, 16'h0004, 1, 0, 1, 1);
    expect_out("wrap_carry", 1, 32'h0000_000C, 32'hFFFF_FFFC, 1, 32'h0000_000C, 1, 0);
    step(32'h0000_0000, 16'hFFFF, 0, 0, 0, 1);
    expect_out("no_borrow", 1, 32'h0000_0000, 32'h0000_0004, 0, 32'h0000_0004, 0, 0);
    step(32'h0001_0000, 16'h7FFF, 0, 1, 0, 1);
    expect_out("max_pos", 1, 32'h0003_0000, 32'h0001_0004, 1, 32'h0003_0000, 0, 0);
    step(32'h0001_0000, 16'h8000, 1, 0, 0, 1);
    expect_out("max_neg", 1, 32'hFFFF_0004, 32'h0001_0004, 0, 32'h0001_0004, 1, 0);
    step(32'hFFFF_FFFC, 16'h0000, 1, 1, 0, 1);
    expect_out("plus4_wrap_both", 1, 32'h0000_0000, 32'h0000_0000, 1, 32'h0000_0000, 1, 0);

    step(32'h0000_1002, 16'h0000, 1, 0, 0, 1);
    expect_out("misaligned", 1, 32'h0000_1006, 32'h0000_1006, 0, 32'h0000_1006, 0, 1);
    step(32'h5555_0000, 16'h1234, 1, 0, 1, 0);
    expect_out("hold", 0, 32'h0000_1006, 32'h0000_1006, 0, 32'h0000_1006, 0, 1);
    step(32'h0000_2000, 16'h0001, 0, 1, 0, 1);
    expect_out("resume", 1, 32'h0000_2008, 32'h0000_2004, 1, 32'h0000_2008, 0, 0);

    step(32'h0000_3000, 16'h0001, 1, 0, 1, 1);
    #1 rst_n = 1'b0;
    #1 expect_out("reset_mid", 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 drive(32'h0000_4000, 16'h0010, 1, 0, 1, 1);
    #1 expect_out("reset_low_edge", 0, 0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 expect_out("after_reset", 1, 32'h0000_4044, 32'h0000_4004, 1, 32'h0000_4044, 0, 0);

    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0:       pc = W'($urandom);
        1:       pc = 32'hFFFF_FFE0 | W'($urandom_range(0, 31));
        2:       pc = W'($urandom_range(0, 64));
        default: pc = W'($urandom) & 32'hFFFF_FFFC;
      endcase
      case ($urandom_range(0, 7))
        0:       imm = 16'h7FFF;
        1:       imm = 16'h8000;
        2:       imm = 16'hFFFF;
        default: imm = IW'($urandom);
      endcase
      step(pc, imm, 1'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 3) != 0);
      if (i == 300) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    @(posedge clk);
    #1 cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
